// File: rtl/lpm_counter_arb_if.sv
// Request/grant bus between the timing clients and the shared down-counter arbiter.
// master = client side (drives requests), slave = arbiter side.
interface lpm_counter_arb_if #(
  parameter int lpm_width = 8,
  parameter int num_req   = 4,
  parameter int id_width  = 2
);
  logic [num_req-1:0]           req;
  logic [num_req*lpm_width-1:0] req_data;
  logic [num_req-1:0]           gnt;
  logic [num_req-1:0]           done;
  logic                         busy;
  logic [id_width-1:0]          cur_id;
  logic [lpm_width-1:0]         q;

  modport master (
    output req, req_data,
    input  gnt, done, busy, cur_id, q
  );

  modport slave (
    input  req, req_data,
    output gnt, done, busy, cur_id, q
  );
endinterface

// File: rtl/lpm_counter_arb.sv
// Round-robin scheduler sharing one interval down-counter among num_req timing clients.
// Optional macro LPM_COUNTER_ARB_CNT_EN_EN adds a cnt_en input that gates decrements in COUNT.
//
// state | meaning
// IDLE  | no grant; arbitrate among pending requests
// LOAD  | grant issued; load the winner's interval into q
// COUNT | grant held; q decrements toward zero
// DONE  | grant dropped; one-cycle done pulse to the winner
module lpm_counter_arb #(
  parameter int lpm_width = 8,
  parameter int num_req   = 4,
  parameter int id_width  = 2
) (
  input  logic clock,
  input  logic aclr_n,
`ifdef LPM_COUNTER_ARB_CNT_EN_EN
  input  logic cnt_en,
`endif
  lpm_counter_arb_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_COUNT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]             state;
  logic [id_width-1:0]    cur_id;
  logic [id_width-1:0]    start_idx;
  logic [lpm_width-1:0]   q_r;

  logic [2*num_req-1:0]   req_dbl;
  logic [num_req-1:0]     req_rot;
  logic                   pick_vld;
  int                     pick_sum;
  logic [id_width-1:0]    pick_id;
  logic [id_width-1:0]    next_start;
  logic [lpm_width-1:0]   cur_data;
  logic                   req_own;
  logic                   cnt_step;
  logic [num_req-1:0]     id_onehot;

`ifdef LPM_COUNTER_ARB_CNT_EN_EN
  assign cnt_step = cnt_en;
`else
  assign cnt_step = 1'b1;
`endif

  // Rotate so the search begins at start_idx, then take the lowest set bit.
  assign req_dbl = {bus.req, bus.req};
  assign req_rot = req_dbl[start_idx +: num_req];

  always_comb begin
    pick_vld = 1'b0;
    pick_sum = 0;
    for (int k = 0; k < num_req; k++) begin
      if (!pick_vld && req_rot[k]) begin
        pick_vld = 1'b1;
        pick_sum = int'(start_idx) + k;
      end
    end
    if (pick_sum >= num_req) pick_sum = pick_sum - num_req;
  end

  assign pick_id = id_width'(pick_sum);

  always_comb begin
    if (int'(cur_id) == num_req - 1) next_start = '0;
    else                             next_start = cur_id + id_width'(1);
  end

  always_comb begin
    cur_data = '0;
    for (int i = 0; i < num_req; i++) begin
      if (cur_id == id_width'(i)) cur_data = bus.req_data[i*lpm_width +: lpm_width];
    end
  end

  assign req_own   = bus.req[cur_id];
  assign id_onehot = num_req'(1) << cur_id;

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state     <= ST_IDLE;
      cur_id    <= '0;
      start_idx <= '0;
      q_r       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            cur_id <= pick_id;
            state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // Abort wins over the load so q keeps its previous value.
          if (!req_own) begin
            state     <= ST_IDLE;
            start_idx <= next_start;
          end else begin
            q_r   <= cur_data;
            state <= (cur_data == '0) ? ST_DONE : ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (!req_own) begin
            state     <= ST_IDLE;
            start_idx <= next_start;
          end else if (cnt_step && q_r != '0) begin
            q_r <= q_r - lpm_width'(1);
            if (q_r == lpm_width'(1)) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          start_idx <= next_start;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt    = (state == ST_LOAD || state == ST_COUNT) ? id_onehot : '0;
  assign bus.done   = (state == ST_DONE) ? id_onehot : '0;
  assign bus.busy   = (state != ST_IDLE);
  assign bus.cur_id = cur_id;
  assign bus.q      = q_r;

endmodule
